// File: rtl/classify_arbiter.sv
// classify_arbiter: shares one maxfinder among NUM_REQ requesters.
//
// A round-robin grant picks one requester, its score vector is sent to the
// maxfinder with a single-cycle start pulse, and the returned label is held
// for the granted requester until it accepts the response.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_data          requester r's vector at slice r
//   mf_i_data/valid   vector and start pulse to the maxfinder
//   mf_o_data/valid   label and result strobe from the maxfinder
//   rsp_valid/ready   per-requester response handshake (valid is one-hot)
//   rsp_label         returned label
//   rsp_error         response is a watchdog timeout
//   busy              high in every state except IDLE
//
// Optional build macro: CLASSIFY_ARB_TIMEOUT_EN adds a WAIT watchdog of
// TIMEOUT cycles; without it WAIT waits forever and rsp_error is 0.
//
// state | meaning
// IDLE  | waiting for any req_valid; grant is combinational
// ISSUE | one-cycle maxfinder start pulse
// WAIT  | waiting for the maxfinder result strobe
// RESP  | response held until the granted requester accepts it
module classify_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int TIMEOUT     = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_REQ-1:0]                       req_valid,
  input  logic [NUM_REQ*NUM_INPUT*INPUT_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                       req_ready,
  output logic [NUM_INPUT*INPUT_WIDTH-1:0]         mf_i_data,
  output logic                                     mf_i_valid,
  input  logic [3:0]                               mf_o_data,
  input  logic                                     mf_o_data_valid,
  output logic [NUM_REQ-1:0]                       rsp_valid,
  input  logic [NUM_REQ-1:0]                       rsp_ready,
  output logic [3:0]                               rsp_label,
  output logic                                     rsp_error,
  output logic                                     busy
);

  localparam int VW = NUM_INPUT * INPUT_WIDTH;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt;
  logic [PW-1:0] pick;
  logic          pick_any;

`ifdef CLASSIFY_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          err_q;
  assign rsp_error = err_q;
`else
  assign rsp_error = 1'b0;
`endif

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_w;
    pick     = ptr;
    pick_any = 1'b0;
    idx      = 0;
    idx_w    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx   = (int'(ptr) + i) % NUM_REQ;
      idx_w = PW'(idx);
      if (req_valid[idx_w]) begin
        pick     = idx_w;
        pick_any = 1'b1;
      end
    end
  end

  // Gated with rst so no accept is ever offered while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst && (state == IDLE) && pick_any) req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[gnt] = 1'b1;
  end

  assign mf_i_valid = (state == ISSUE);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      mf_i_data <= '0;
      rsp_label <= '0;
`ifdef CLASSIFY_ARB_TIMEOUT_EN
      wd_cnt    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            gnt       <= pick;
            mf_i_data <= req_data[pick*VW +: VW];
            state     <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef CLASSIFY_ARB_TIMEOUT_EN
          // Terminal count 0 is reached on the TIMEOUT-th WAIT cycle.
          wd_cnt <= CW'(TIMEOUT - 1);
`endif
          state  <= WAIT;
        end
        WAIT: begin
          if (mf_o_data_valid) begin
            rsp_label <= mf_o_data;
`ifdef CLASSIFY_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state     <= RESP;
          end
`ifdef CLASSIFY_ARB_TIMEOUT_EN
          else if (wd_cnt == '0) begin
            rsp_label <= 4'hF;
            err_q     <= 1'b1;
            state     <= RESP;
          end else begin
            wd_cnt <= wd_cnt - CW'(1);
          end
`endif
        end
        RESP: begin
          if (rsp_ready[gnt]) begin
            ptr   <= (gnt == PW'(NUM_REQ - 1)) ? '0 : gnt + PW'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_classify_arbiter.sv
module tb_classify_arbiter;

  localparam int NR = 4;
  localparam int NI = 10;
  localparam int IW = 16;
  localparam int VW = NI * IW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*VW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic [VW-1:0]     mf_i_data;
  logic              mf_i_valid;
  logic [3:0]        mf_o_data = 4'd0;
  logic              mf_o_data_valid = 1'b0;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [3:0]        rsp_label;
  logic              rsp_error;
  logic              busy;

  classify_arbiter #(
    .NUM_REQ(NR), .NUM_INPUT(NI), .INPUT_WIDTH(IW), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .mf_i_data(mf_i_data), .mf_i_valid(mf_i_valid),
    .mf_o_data(mf_o_data), .mf_o_data_valid(mf_o_data_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_label(rsp_label), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [3:0] lbl;
    logic       err;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  int            grants = 0;
  int            pulses = 0;
  int            rsps   = 0;
  int            cur_gnt = 0;
  int            mi [NR] = '{3, 7, 9, 0};   // index of the max score per requester
  logic [VW-1:0] vec [NR];
  int            exp_gnt [$];
  rsp_t          exp_rsp [$];

  // maxfinder model state
  bit            mf_en = 1'b1;
  int            mf_cnt = 0;
  logic [3:0]    mf_lbl = 4'd0;
  logic          prev_mfv = 1'b0;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_txn(input int r, input logic [3:0] lbl, input logic err, input bit with_rsp);
    rsp_t e;
    exp_gnt.push_back(r);
    if (with_rsp) begin
      e.r = r; e.lbl = lbl; e.err = err;
      exp_rsp.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic wait_rsps(input int target, input string nm);
    int n = 0;
    while (rsps < target && n < 500) begin @(negedge clk); #1; n++; end
    chk(nm, (rsps >= target), 1);
  endtask

  // grant monitor
  always @(negedge clk) begin
    if (rst && req_ready != '0) begin
      grants++;
      chk("grant_in_idle", busy, 0);
      if (exp_gnt.size() == 0) chk("unexpected_grant", req_ready, 0);
      else begin
        cur_gnt = exp_gnt.pop_front();
        chk("grant", req_ready, 1 << cur_gnt);
      end
    end
  end

  // maxfinder model: result strobe NI+1 cycles after the start pulse
  always @(negedge clk) begin
    logic [IW-1:0] best;
    if (mf_o_data_valid) mf_o_data_valid = 1'b0;
    if (mf_i_valid) begin
      pulses++;
      chk("mf_pulse_single_cycle", prev_mfv, 0);
      chk("mf_i_data", mf_i_data, vec[cur_gnt]);
      best = mf_i_data[IW-1:0];
      mf_lbl = 4'd0;
      for (int i = 1; i < NI; i++) begin
        if (mf_i_data[i*IW +: IW] > best) begin
          best = mf_i_data[i*IW +: IW];
          mf_lbl = 4'(i);
        end
      end
      mf_cnt = NI + 1;
    end else if (mf_cnt > 0) begin
      mf_cnt--;
      if (mf_cnt == 0 && mf_en) begin
        mf_o_data = mf_lbl;
        mf_o_data_valid = 1'b1;
      end
    end
    prev_mfv = mf_i_valid;
  end

  // response monitor / scoreboard
  always @(negedge clk) begin
    rsp_t e;
    if ((rsp_valid & rsp_ready) != '0) begin
      rsps++;
      if (exp_rsp.size() == 0) chk("unexpected_response", rsp_valid, 0);
      else begin
        e = exp_rsp.pop_front();
        chk("rsp_valid", rsp_valid, 1 << e.r);
        chk("rsp_label", rsp_label, e.lbl);
        chk("rsp_error", rsp_error, e.err);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    int  order [5] = '{0, 1, 2, 3, 0};

    for (int r = 0; r < NR; r++) begin
      for (int i = 0; i < NI; i++)
        vec[r][i*IW +: IW] = (i == mi[r]) ? 16'(16'hF000 + r) : 16'(16'h0100 * (r + 1) + i);
      req_data[r*VW +: VW] = vec[r];
    end
    rst = 1'b0; req_valid = '0; rsp_ready = '0;
    repeat (3) tick();

    chk("rst_req_ready", req_ready, 0);
    chk("rst_mf_i_valid", mf_i_valid, 0);
    chk("rst_mf_i_data", mf_i_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_label", rsp_label, 0);
    chk("rst_rsp_error", rsp_error, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // contention: all requesters held, expect 0,1,2,3,0
    rsp_ready = 4'hF;
    foreach (order[k]) push_txn(order[k], 4'(mi[order[k]]), 1'b0, 1'b1);
    req_valid = 4'hF;
    wait_rsps(5, "contention_done");
    req_valid = '0;
    tick(); tick();
    chk("contention_grants", grants, 5);
    chk("contention_pulses", pulses, 5);

    // single request from requester 1 (ptr now 1)
    wait_idle("single_idle");
    push_txn(1, 4'd7, 1'b0, 1'b1);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_rsps(6, "single_done");

    // response backpressure (ptr 2 -> only requester 0 asks)
    wait_idle("bp_idle");
    rsp_ready = '0;
    push_txn(0, 4'd3, 1'b0, 1'b1);
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0100;  // pending request must not be accepted while in RESP
    n = 0;
    while (rsp_valid == '0 && n < 100) begin tick(); n++; end
    chk("bp_reached_resp", rsp_valid, 4'b0001);
    rsp_ready = 4'b1110;  // bits other than the grant must be ignored
    repeat (5) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_rsp_label", rsp_label, 3);
      chk("bp_busy", busy, 1);
      chk("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 4'b0001;
    req_valid = '0;
    tick();
    chk("bp_release_idle", busy, 0);
    chk("bp_done", rsps, 7);

    // reset mid-WAIT (ptr 1 -> requester 2)
    push_txn(2, 4'd9, 1'b0, 1'b0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("rt_issue_pulse", mf_i_valid, 1);
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk("rt_req_ready", req_ready, 0);
    chk("rt_mf_i_valid", mf_i_valid, 0);
    chk("rt_mf_i_data", mf_i_data, 0);
    chk("rt_rsp_valid", rsp_valid, 0);
    chk("rt_rsp_label", rsp_label, 0);
    chk("rt_rsp_error", rsp_error, 0);
    chk("rt_busy", busy, 0);
    rst = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      tick();
      if (rsp_valid != '0 || busy) seen = 1'b1;
    end
    chk("rt_late_strobe_ignored", seen, 0);

    // ptr must be 0 again: 4'b1001 grants 0, not 3
    rsp_ready = 4'hF;
    push_txn(0, 4'd3, 1'b0, 1'b1);
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    wait_rsps(8, "ptr_reset_done");

    // maxfinder strobe suppressed
    wait_idle("to_idle");
    mf_en = 1'b0;
    rsp_ready = '0;
`ifdef CLASSIFY_ARB_TIMEOUT_EN
    push_txn(3, 4'hF, 1'b1, 1'b1);
`else
    push_txn(3, 4'hF, 1'b1, 1'b0);
`endif
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
`ifdef CLASSIFY_ARB_TIMEOUT_EN
    n = 0;
    while (rsp_valid == '0 && n < 200) begin tick(); n++; end
    chk("to_latency", n, 33);
    rsp_ready = 4'b1000;
    wait_rsps(9, "to_done");
`else
    repeat (60) tick();
    chk("no_to_busy", busy, 1);
    chk("no_to_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
`endif
    mf_en = 1'b1;
    repeat (3) tick();

    chk("exp_gnt_empty", exp_gnt.size(), 0);
    chk("exp_rsp_empty", exp_rsp.size(), 0);
    chk("pulses_eq_grants", pulses, grants);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
